// File: rtl/adc_scan_sampler.sv
// Serial-ADC scan engine: walks the enabled channels in CH_MASK, runs one
// 13-clock conversion per channel and presents each result with a one-cycle strobe.
module adc_scan_sampler #(
  parameter int          CLK_DIV    = 4,
  parameter int          GAP_CYCLES = 8,
  parameter logic [9:0]  CH_MASK    = 10'b11_1111_0011
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scan_en,
  input  logic       i_miso,
  output logic       o_cs_n,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_new_sample,
  output logic [7:0] o_sample,
  output logic [7:0] o_sample_channel,
  output logic       o_busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  function automatic logic [3:0] lowestBit(input logic [9:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  localparam logic [3:0]  FIRST_CH  = lowestBit(CH_MASK);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [4:0]  LAST_EDGE = 5'd26;

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_cnt;
  logic [4:0]  r_edgeCnt;
  logic [7:0]  r_shift;
  logic [3:0]  r_addr;
  logic        r_csN;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_newSample;
  logic [7:0]  r_sample;
  logic [7:0]  r_sampleCh;
  logic        r_busy;

  logic        w_cntDone;
  logic [4:0]  w_toggleIdx;
  logic [3:0]  w_nextAddr;
  logic        w_found;

  assign w_cntDone   = (r_cnt == ((r_state == GAP) ? GAP_LAST : DIV_LAST));
  assign w_toggleIdx = r_edgeCnt + 5'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (i_scan_en && (CH_MASK != 10'd0)) w_stateNext = SETUP;
      SETUP:   if (w_cntDone) w_stateNext = SHIFT;
      SHIFT:   if (w_cntDone && (r_edgeCnt == LAST_EDGE)) w_stateNext = DONE;
      DONE:    w_stateNext = GAP;
      GAP:     if (w_cntDone) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Next enabled channel strictly above the current one, else wrap to the lowest.
  always_comb begin
    w_nextAddr = FIRST_CH;
    w_found    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!w_found && CH_MASK[i] && (4'(i) > r_addr)) begin
        w_nextAddr = 4'(i);
        w_found    = 1'b1;
      end
    end
  end

  // Toggle n of sclk: odd n is rise (n+1)/2, even n is fall n/2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= 16'd0;
      r_edgeCnt   <= 5'd0;
      r_shift     <= 8'd0;
      r_addr      <= FIRST_CH;
      r_csN       <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_newSample <= 1'b0;
      r_sample    <= 8'd0;
      r_sampleCh  <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_newSample <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= 16'd0;
          if (w_stateNext == SETUP) begin
            r_csN     <= 1'b0;
            r_busy    <= 1'b1;
            r_mosi    <= r_addr[3];
            r_edgeCnt <= 5'd0;
            r_shift   <= 8'd0;
          end
        end
        SETUP: begin
          if (w_cntDone) begin
            r_cnt     <= 16'd0;
            r_sclk    <= 1'b1;
            r_edgeCnt <= 5'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (!w_cntDone) begin
            r_cnt <= r_cnt + 16'd1;
          end else if (r_edgeCnt == LAST_EDGE) begin
            r_cnt       <= 16'd0;
            r_csN       <= 1'b1;
            r_newSample <= 1'b1;
            r_sample    <= r_shift;
            r_sampleCh  <= {4'b0000, r_addr};
            r_addr      <= w_nextAddr;
          end else begin
            r_cnt     <= 16'd0;
            r_sclk    <= ~r_sclk;
            r_edgeCnt <= w_toggleIdx;
            if (w_toggleIdx[0]) begin
              if (w_toggleIdx >= 5'd11) r_shift <= {r_shift[6:0], i_miso};
            end else begin
              case (w_toggleIdx)
                5'd2:    r_mosi <= r_addr[2];
                5'd4:    r_mosi <= r_addr[1];
                5'd6:    r_mosi <= r_addr[0];
                default: r_mosi <= 1'b0;
              endcase
            end
          end
        end
        DONE: begin
          r_cnt <= 16'd0;
        end
        GAP: begin
          if (w_cntDone) begin
            r_cnt  <= 16'd0;
            r_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_cnt <= 16'd0;
      endcase
    end
  end

  assign o_cs_n           = r_csN;
  assign o_sclk           = r_sclk;
  assign o_mosi           = r_mosi;
  assign o_new_sample     = r_newSample;
  assign o_sample         = r_sample;
  assign o_sample_channel = r_sampleCh;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_adc_scan_sampler.sv
// Bench for adc_scan_sampler: behavioural ADC on the serial pins, a stimulus queue
// of ADC results and a scoreboard of expected strobes.
`timescale 1ns/1ps
module tb_adc_scan_sampler;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       scanEn = 1'b0;
  logic       forceMiso = 1'b0;
  logic       modelMiso = 1'b0;
  logic       miso;
  logic       csN, sclk, mosi, newSample, busy;
  logic [7:0] sample, sampleCh;

  assign miso = forceMiso | modelMiso;

  always #5 clk = ~clk;

  adc_scan_sampler #(.CLK_DIV(4), .GAP_CYCLES(8), .CH_MASK(10'b11_1111_0011)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_scan_en(scanEn), .i_miso(miso),
    .o_cs_n(csN), .o_sclk(sclk), .o_mosi(mosi), .o_new_sample(newSample),
    .o_sample(sample), .o_sample_channel(sampleCh), .o_busy(busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] expCh;
    logic [7:0] expSample;
  } vec_t;

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] smp;
  } exp_t;

  localparam logic [31:0] RESET_OUTS = 32'h0010_0000;

  vec_t       stimQ[$];
  exp_t       sbQ[$];
  vec_t       scanVec[9];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         startCyc = 0;
  int         lastStrobe = -1;
  int         riseCnt = 0;
  int         fallCnt = 0;
  int         lateMosi = 0;
  int         csLowCount;
  int         resetStrobes;
  logic [3:0] modelAddr = 4'd0;
  logic [7:0] curData = 8'd0;
  logic       prevCsN = 1'b1;
  logic       prevSclk = 1'b0;
  logic       prevNew = 1'b0;
  logic       sawStrobe = 1'b0;
  logic       spacingOn = 1'b0;
  logic       csSeen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] ch, input logic [7:0] smp);
    vec_t v;
    v.data      = data;
    v.expCh     = ch;
    v.expSample = smp;
    stimQ.push_back(v);
  endtask

  function automatic logic [31:0] outVector();
    return 32'({csN, sclk, mosi, newSample, busy, sample, sampleCh});
  endfunction

  // One clock of ADC model plus scoreboard, evaluated on the falling clk edge.
  task automatic tick();
    vec_t v;
    exp_t e;
    @(negedge clk);
    cyc++;
    sawStrobe = 1'b0;
    if (!rstN) begin
      sbQ.delete();
      lastStrobe = -1;
    end
    if (prevCsN && !csN) begin
      startCyc  = cyc;
      riseCnt   = 0;
      fallCnt   = 0;
      lateMosi  = 0;
      modelAddr = 4'd0;
      modelMiso = 1'b0;
      if (stimQ.size() == 0) begin
        checkOutput("unexpected_start", 32'(stimQ.size()), 32'd1);
        curData = 8'd0;
      end else begin
        v       = stimQ.pop_front();
        curData = v.data;
        e.ch    = v.expCh;
        e.smp   = v.expSample;
        sbQ.push_back(e);
      end
    end
    if (csN != prevCsN) checkOutput("cs_change_sclk_low", 32'(sclk), 32'd0);
    if (!csN && sclk && !prevSclk) begin
      riseCnt++;
      if (riseCnt <= 4) modelAddr = {modelAddr[2:0], mosi};
      else if (mosi) lateMosi++;
      if (riseCnt == 4 && sbQ.size() > 0)
        checkOutput("mosi_addr", 32'(modelAddr), 32'(sbQ[sbQ.size()-1].ch[3:0]));
      if (riseCnt == 13) checkOutput("mosi_after_addr", 32'(lateMosi), 32'd0);
    end
    if (!csN && !sclk && prevSclk) begin
      fallCnt++;
      if (fallCnt >= 5 && fallCnt <= 12) modelMiso = curData[3'(12 - fallCnt)];
      else modelMiso = 1'b0;
    end
    if (newSample) begin
      sawStrobe = 1'b1;
      checkOutput("strobe_width", 32'(prevNew), 32'd0);
      if (sbQ.size() == 0) begin
        checkOutput("strobe_expected", 32'(sbQ.size()), 32'd1);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sample", 32'(sample), 32'(e.smp));
        checkOutput("sample_channel", 32'(sampleCh), 32'(e.ch));
      end
      checkOutput("strobe_latency", 32'(cyc - startCyc), 32'd108);
      if (spacingOn && lastStrobe >= 0)
        checkOutput("strobe_spacing", 32'(cyc - lastStrobe), 32'd118);
      lastStrobe = cyc;
    end
    prevCsN  = csN;
    prevSclk = sclk;
    prevNew  = newSample;
  endtask

  task automatic waitStrobe(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sawStrobe) break;
    end
    checkOutput("strobe_timeout", 32'(sawStrobe), 32'd1);
  endtask

  task automatic waitCsLow(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!csN) break;
    end
    checkOutput("start_timeout", 32'(csN), 32'd0);
  endtask

  initial begin
    scanVec[0] = '{8'h10, 8'h00, 8'h10};
    scanVec[1] = '{8'h11, 8'h01, 8'h11};
    scanVec[2] = '{8'h14, 8'h04, 8'h14};
    scanVec[3] = '{8'h15, 8'h05, 8'h15};
    scanVec[4] = '{8'h16, 8'h06, 8'h16};
    scanVec[5] = '{8'h17, 8'h07, 8'h17};
    scanVec[6] = '{8'h18, 8'h08, 8'h18};
    scanVec[7] = '{8'h19, 8'h09, 8'h19};
    scanVec[8] = '{8'h10, 8'h00, 8'h10};

    $display("[TB] reset with scan_en and miso high");
    rstN = 1'b0; scanEn = 1'b1; forceMiso = 1'b1;
    repeat (6) begin
      tick();
      checkOutput("reset_outputs", outVector(), RESET_OUTS);
    end

    $display("[TB] single conversion, channel 0 returns A5");
    applyStimulus(8'hA5, 8'h00, 8'hA5);
    rstN = 1'b1; forceMiso = 1'b0;
    csSeen = 1'b0;
    repeat (2) begin
      tick();
      if (!csN) csSeen = 1'b1;
    end
    checkOutput("cs_fall_after_reset", 32'(csSeen), 32'd1);
    checkOutput("busy_in_conversion", 32'(busy), 32'd1);
    scanEn = 1'b0;
    waitStrobe(150);
    repeat (20) tick();
    checkOutput("busy_after_gap", 32'(busy), 32'd0);
    checkOutput("idle_cs_high", 32'(csN), 32'd1);

    $display("[TB] full scan order from channel 0");
    rstN = 1'b0;
    repeat (2) tick();
    rstN = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) applyStimulus(scanVec[i].data, scanVec[i].expCh, scanVec[i].expSample);
    spacingOn = 1'b1;
    scanEn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      waitStrobe(150);
      checkOutput("scan_vec_channel", 32'(sampleCh), 32'(scanVec[i].expCh));
      if (i == 8) scanEn = 1'b0;
    end
    spacingOn = 1'b0;
    repeat (20) tick();

    $display("[TB] scan_en dropped at cycle 50");
    applyStimulus(8'hC3, 8'h01, 8'hC3);
    scanEn = 1'b1;
    waitCsLow(20);
    for (int i = 0; i < 100 && (cyc - startCyc) < 50; i++) tick();
    scanEn = 1'b0;
    waitStrobe(100);
    repeat (12) tick();
    checkOutput("busy_low_after_drop", 32'(busy), 32'd0);
    csLowCount = 0;
    repeat (150) begin
      tick();
      if (!csN) csLowCount++;
    end
    checkOutput("cs_stays_high", 32'(csLowCount), 32'd0);

    $display("[TB] reset asserted at cycle 60");
    applyStimulus(8'h77, 8'h04, 8'h77);
    scanEn = 1'b1;
    waitCsLow(20);
    for (int i = 0; i < 100 && (cyc - startCyc) < 60; i++) tick();
    rstN = 1'b0;
    #1;
    checkOutput("reset_async", outVector(), RESET_OUTS);
    resetStrobes = 0;
    repeat (5) begin
      tick();
      if (newSample) resetStrobes++;
    end
    checkOutput("no_strobe_in_reset", 32'(resetStrobes), 32'd0);
    applyStimulus(8'h3C, 8'h00, 8'h3C);
    rstN = 1'b1;
    waitStrobe(150);
    scanEn = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_scan_sampler.md
# adc_scan_sampler

Free-running serial-ADC scan engine that produces the sample stream consumed by the analog channel controller. It walks a fixed list of enabled ADC channels, runs one serial conversion per channel (address out on `mosi`, 8-bit result in on `miso`), and presents each result with a one-cycle `new_sample` strobe, the 8-bit `sample`, and the originating `sample_channel`. It sits between the board-level ADC pins and the controller's `new_sample`/`sample`/`sample_channel` inputs.

## Interface
- `CLK_DIV`, 4: clk cycles per sclk half-period (>=2).
- `GAP_CYCLES`, 8: cycles `cs_n` stays high between conversions (>=1).
- `CH_MASK`, 10'b11_1111_0011: channel enable bits [9:0], bit n = ADC channel n scanned.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `scan_en`  in  1  high = start conversions; sampled only in IDLE.
- `miso`  in  1  ADC serial data out.
- `cs_n`  out  1  ADC chip select, active low.
- `sclk`  out  1  ADC serial clock, idle low.
- `mosi`  out  1  ADC channel address, MSB first.
- `new_sample`  out  1  one-cycle strobe, `sample`/`sample_channel` valid.
- `sample`  out  8  last conversion result.
- `sample_channel`  out  8  channel of `sample`, zero-extended 4-bit address.
- `busy`  out  1  high from first `cs_n` low cycle through end of GAP.

## Operation
- Reset (rst=0, async): `cs_n`=1, `sclk`=0, `mosi`=0, `new_sample`=0, `sample`=0, `sample_channel`=0, `busy`=0, scan pointer = lowest set bit of `CH_MASK`, state IDLE.
- States: IDLE -> SETUP -> SHIFT -> DONE -> GAP -> IDLE.
- IDLE: if `scan_en`=1 at a clk edge, next cycle enters SETUP: `cs_n`=0, `busy`=1, `mosi`=addr[3]. Otherwise stay; `busy`=0.
- SETUP: hold `CLK_DIV` cycles, `sclk`=0, then SHIFT.
- SHIFT: `sclk` toggles every `CLK_DIV` cycles, 13 rising edges total.
  - Rising 1-4: ADC latches addr[3..0]. `mosi` advances to next address bit on falling edges 1-3; `mosi`=0 from falling edge 4 on.
  - Rising 5: null bit, `miso` ignored.
  - Rising 6-13: `miso` shifted in MSB first, sampled on the clk edge that drives `sclk` high.
  - After falling edge 13 (`sclk` low for `CLK_DIV` cycles), go DONE.
- DONE (1 cycle): `cs_n`=1, `new_sample`=1, `sample`=shift register, `sample_channel`={4'b0, addr}; scan pointer advances to next set bit of `CH_MASK` above current, wrapping to lowest set bit.
- GAP: `cs_n`=1 for `GAP_CYCLES` cycles, then IDLE.
- `sample`/`sample_channel` hold between DONE cycles.
- `scan_en` falling mid-conversion: current conversion completes including DONE and GAP; no new one starts.
- `CH_MASK`=0: block never leaves IDLE, `busy`=0, no strobes.
- Single enabled channel: every conversion uses that address.
- Reset mid-conversion: all outputs to reset values immediately, partial result discarded, no `new_sample`.

## Timing
- Cycle 0 = first cycle `cs_n`=0. First `sclk` rise at cycle `CLK_DIV`; last fall at 26*`CLK_DIV`; `new_sample` high in cycle 27*`CLK_DIV`.
- Conversion period with `scan_en` held high: 27*`CLK_DIV` + `GAP_CYCLES` + 2 cycles (defaults: 118).
- `new_sample` exactly 1 cycle wide; never two strobes closer than one period.
- `mosi` stable across every `sclk` rising edge; `cs_n` changes only while `sclk`=0.
- All outputs registered; no combinational path from `miso` or `scan_en` to outputs.

## Test plan
- Reset: hold rst=0 with `scan_en`=1 and `miso`=1 -> all outputs at reset values, no `sclk` activity; release -> `cs_n` falls within 2 cycles.
- Single conversion, defaults, ADC model returns 8'hA5 for channel 0 -> `mosi` bits 0,0,0,0 on rises 1-4; `new_sample` at cycle 108, `sample`=8'hA5, `sample_channel`=8'h00.
- Scan order, defaults, model returns 8'h10+n for channel n -> strobes in order 0,1,4,5,6,7,8,9,0 with matching samples, strobe spacing 118 cycles.
- Channel 9 addressing -> `mosi` bits 1,0,0,1 on rises 1-4; `sample_channel`=8'h09; next conversion wraps to channel 0.
- `scan_en` dropped at cycle 50 of a conversion -> that conversion's `new_sample` still occurs at cycle 108, `busy` low after GAP, `cs_n` stays high thereafter.
- rst asserted at cycle 60 -> `cs_n`=1, `sclk`=0 same cycle, no `new_sample`, `sample` reads 0; after release scan restarts at channel 0.
